jtshouse_scr_sched: RTL and testbench

Fetch scheduler for the C123 tilemap engine. It collects per-layer tile-boundary requests from the six layers (4 scroll + 2 fix) and serialises them onto the single tile-map BRAM port and the single mask-ROM SDRAM port. Each delivered result is a load strobe carrying the layer number, tile code and mask byte. It also drives the stall signal that holds the pixel counter while fetches are outstanding. It sits between the pixel-counter logic and the memory ports inside the scroll renderer.

---
 rtl/jtshouse_scr_sched.sv | 243 ++++++++++++++++++++++++
 tb/tb_jtshouse_scr_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtshouse_scr_sched.sv
// Tile fetch scheduler: serialises per-layer tile requests onto one tile-map BRAM port and one mask-ROM port.
// Latency: request to grant is 2 cycles; service is TMAP_LAT+3 cycles from grant, plus any mask_ok wait.
// Backpressure: mask_cs is held until mask_ok is seen; stall holds the pixel counter while work is pending.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   hs_edge           line start: flushes pending and in-flight work and clears overrun
//   active, lyr_req,  per-layer request pulses, accepted only while active=1 and the
//   lyr_dis           layer is not disabled
//   gnt_lyr, vsub     layer being serviced (7 = none); vsub is the datapath's tile row for it
//   tmap_rd/tmap_data tile-map BRAM read strobe and returned word (bits 13:0 = tile code)
//   mask_cs/mask_addr mask-ROM request and address {code, vsub}; mask_ok/mask_data = returned byte
//   ld_we/ld_*        one-cycle load strobe with layer, tile code and mask byte
//   stall, overrun    fetch-busy indication, sticky re-request flag
//
// Build option: define JTSHOUSE_SCHED_RR_EN for round-robin arbitration
// (default is fixed priority, lowest layer index wins).
module jtshouse_scr_sched #(
  parameter int TMAP_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_edge,
  input  logic        active,
  input  logic [5:0]  lyr_req,
  input  logic [5:0]  lyr_dis,
  input  logic [2:0]  vsub,
  output logic [2:0]  gnt_lyr,
  output logic        tmap_rd,
  input  logic [15:0] tmap_data,
  output logic        mask_cs,
  output logic [16:0] mask_addr,
  input  logic        mask_ok,
  input  logic [7:0]  mask_data,
  output logic        ld_we,
  output logic [2:0]  ld_lyr,
  output logic [13:0] ld_code,
  output logic [7:0]  ld_mask,
  output logic        stall,
  output logic        overrun
);

  typedef enum logic [2:0] {S_IDLE, S_TMAP, S_WAIT, S_MASK, S_LOAD} state_t;

  localparam logic [2:0] NO_LYR    = 3'd7;
  // Index of the last WAIT cycle; unused when TMAP_LAT = 1 (TMAP goes straight to MASK).
  localparam logic [1:0] WAIT_LAST = 2'(TMAP_LAT - 2);

  state_t      state_q, state_d;
  logic [5:0]  pend_q, pend_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic [13:0] code_q, code_d;
  logic        cs_prev_q, cs_prev_d;
  logic [2:0]  gnt_lyr_q, gnt_lyr_d;
  logic        tmap_rd_q, tmap_rd_d;
  logic        mask_cs_q, mask_cs_d;
  logic [16:0] mask_addr_q, mask_addr_d;
  logic        ld_we_q, ld_we_d;
  logic [2:0]  ld_lyr_q, ld_lyr_d;
  logic [13:0] ld_code_q, ld_code_d;
  logic [7:0]  ld_mask_q, ld_mask_d;
  logic        stall_q, stall_d;
  logic        overrun_q, overrun_d;

  logic [5:0]  req_v;
  logic        pick_vld;
  logic [2:0]  pick_lyr;
  logic [2:0]  pick_idx;
  logic        go_mask;
  logic        unused_tmap_hi;

`ifdef JTSHOUSE_SCHED_RR_EN
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]  pick_sum;
`endif

  assign req_v          = lyr_req & ~lyr_dis & {6{active}};
  assign unused_tmap_hi = ^tmap_data[15:14];

  // Arbiter: first pending layer found scanning upward from the start point.
  always_comb begin
    pick_vld = 1'b0;
    pick_lyr = 3'd0;
    pick_idx = 3'd0;
`ifdef JTSHOUSE_SCHED_RR_EN
    pick_sum = 4'd0;
`endif
    for (int i = 0; i < 6; i++) begin
`ifdef JTSHOUSE_SCHED_RR_EN
      pick_sum = {1'b0, rr_ptr_q} + 4'(i);
      pick_idx = (pick_sum >= 4'd6) ? 3'(pick_sum - 4'd6) : 3'(pick_sum);
`else
      pick_idx = 3'(i);
`endif
      if (!pick_vld && pend_q[pick_idx]) begin
        pick_vld = 1'b1;
        pick_lyr = pick_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    wcnt_d      = wcnt_q;
    code_d      = code_q;
    cs_prev_d   = mask_cs_q;
    gnt_lyr_d   = gnt_lyr_q;
    mask_cs_d   = mask_cs_q;
    mask_addr_d = mask_addr_q;
    ld_lyr_d    = ld_lyr_q;
    ld_code_d   = ld_code_q;
    ld_mask_d   = ld_mask_q;
    overrun_d   = overrun_q;
    go_mask     = 1'b0;
`ifdef JTSHOUSE_SCHED_RR_EN
    rr_ptr_d    = rr_ptr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d   = S_TMAP;
          gnt_lyr_d = pick_lyr;
`ifdef JTSHOUSE_SCHED_RR_EN
          rr_ptr_d  = (pick_lyr == 3'd5) ? 3'd0 : pick_lyr + 3'd1;
`endif
        end
      end
      S_TMAP: begin
        if (TMAP_LAT == 1) begin
          go_mask = 1'b1;
        end else begin
          state_d = S_WAIT;
          wcnt_d  = 2'd0;
        end
      end
      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) go_mask = 1'b1;
        else                     wcnt_d  = wcnt_q + 2'd1;
      end
      S_MASK: begin
        // An ok seen in the first MASK cycle belongs to some earlier access.
        if (mask_ok && cs_prev_q) begin
          state_d   = S_LOAD;
          mask_cs_d = 1'b0;
          ld_lyr_d  = gnt_lyr_q;
          ld_code_d = code_q;
          ld_mask_d = mask_data;
        end
      end
      S_LOAD: begin
        state_d           = S_IDLE;
        gnt_lyr_d         = NO_LYR;
        pend_d[gnt_lyr_q] = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // vsub is already valid here because gnt_lyr has been stable since the grant.
    if (go_mask) begin
      state_d     = S_MASK;
      code_d      = tmap_data[13:0];
      mask_addr_d = {tmap_data[13:0], vsub};
      mask_cs_d   = 1'b1;
    end

    if (hs_edge) begin
      state_d   = S_IDLE;
      gnt_lyr_d = NO_LYR;
      mask_cs_d = 1'b0;
      pend_d    = 6'd0;
      overrun_d = 1'b0;
`ifdef JTSHOUSE_SCHED_RR_EN
      rr_ptr_d  = 3'd0;
`endif
    end

    // A granted layer keeps its pending bit until its load, so checking pend_q
    // also catches re-requests of the layer in service. New requests are applied
    // after the flush, so a request coincident with hs_edge survives.
    if (!hs_edge && |(req_v & pend_q)) overrun_d = 1'b1;
    pend_d = pend_d | req_v;

    tmap_rd_d = (state_d == S_TMAP);
    ld_we_d   = (state_d == S_LOAD);
    stall_d   = (|pend_d) || (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pend_q      <= 6'd0;
      wcnt_q      <= 2'd0;
      code_q      <= 14'd0;
      cs_prev_q   <= 1'b0;
      gnt_lyr_q   <= NO_LYR;
      tmap_rd_q   <= 1'b0;
      mask_cs_q   <= 1'b0;
      mask_addr_q <= 17'd0;
      ld_we_q     <= 1'b0;
      ld_lyr_q    <= 3'd0;
      ld_code_q   <= 14'd0;
      ld_mask_q   <= 8'd0;
      stall_q     <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef JTSHOUSE_SCHED_RR_EN
      rr_ptr_q    <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      wcnt_q      <= wcnt_d;
      code_q      <= code_d;
      cs_prev_q   <= cs_prev_d;
      gnt_lyr_q   <= gnt_lyr_d;
      tmap_rd_q   <= tmap_rd_d;
      mask_cs_q   <= mask_cs_d;
      mask_addr_q <= mask_addr_d;
      ld_we_q     <= ld_we_d;
      ld_lyr_q    <= ld_lyr_d;
      ld_code_q   <= ld_code_d;
      ld_mask_q   <= ld_mask_d;
      stall_q     <= stall_d;
      overrun_q   <= overrun_d;
`ifdef JTSHOUSE_SCHED_RR_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign gnt_lyr   = gnt_lyr_q;
  assign tmap_rd   = tmap_rd_q;
  assign mask_cs   = mask_cs_q;
  assign mask_addr = mask_addr_q;
  assign ld_we     = ld_we_q;
  assign ld_lyr    = ld_lyr_q;
  assign ld_code   = ld_code_q;
  assign ld_mask   = ld_mask_q;
  assign stall     = stall_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_jtshouse_scr_sched.sv
// Directed bench for jtshouse_scr_sched (TMAP_LAT = 2).
// Inputs change and outputs are sampled on the falling clock edge.
// Expected loads are queued when requests are driven and checked as ld_we appears.
module tb_jtshouse_scr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs_edge;
  logic        active;
  logic [5:0]  lyr_req;
  logic [5:0]  lyr_dis;
  logic [2:0]  vsub;
  logic [2:0]  gnt_lyr;
  logic        tmap_rd;
  logic [15:0] tmap_data;
  logic        mask_cs;
  logic [16:0] mask_addr;
  logic        mask_ok;
  logic [7:0]  mask_data;
  logic        ld_we;
  logic [2:0]  ld_lyr;
  logic [13:0] ld_code;
  logic [7:0]  ld_mask;
  logic        stall;
  logic        overrun;

  typedef struct packed {
    logic [2:0]  lyr;
    logic [13:0] code;
    logic [7:0]  mask;
  } ld_t;

  ld_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc, nld, last_ld;

  always #5 clk = ~clk;

  // Simple memory models: tile word and tile row derived from the granted layer.
  assign tmap_data = 16'h1232 + {13'd0, gnt_lyr};
  assign vsub      = ~gnt_lyr;

  jtshouse_scr_sched #(.TMAP_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .hs_edge   (hs_edge),
    .active    (active),
    .lyr_req   (lyr_req),
    .lyr_dis   (lyr_dis),
    .vsub      (vsub),
    .gnt_lyr   (gnt_lyr),
    .tmap_rd   (tmap_rd),
    .tmap_data (tmap_data),
    .mask_cs   (mask_cs),
    .mask_addr (mask_addr),
    .mask_ok   (mask_ok),
    .mask_data (mask_data),
    .ld_we     (ld_we),
    .ld_lyr    (ld_lyr),
    .ld_code   (ld_code),
    .ld_mask   (ld_mask),
    .stall     (stall),
    .overrun   (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input int l, input logic [7:0] m);
    ld_t e;
    e.lyr  = 3'(l);
    e.code = 14'h1232 + 14'(l);
    e.mask = m;
    exp_q.push_back(e);
  endtask

  task automatic run_until_idle(output int c, output int n, output int last);
    c = 0; n = 0; last = 0;
    while (stall === 1'b1 && c < 80) begin
      if (ld_we === 1'b1) begin n++; last = c; end
      tick();
      c++;
    end
    chk("drain_within_bound", 32'(c < 80), 32'd1);
  endtask

  // Scoreboard side: every load must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && ld_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_load", 32'(exp_q.size()), 32'd1);
      end else begin
        ld_t e;
        e = exp_q.pop_front();
        chk("sb_ld_lyr",  32'(ld_lyr),  32'(e.lyr));
        chk("sb_ld_code", 32'(ld_code), 32'(e.code));
        chk("sb_ld_mask", 32'(ld_mask), 32'(e.mask));
      end
    end
  end

  initial begin
    rst = 1'b1; hs_edge = 1'b0; active = 1'b1; lyr_req = 6'd0; lyr_dis = 6'd0;
    mask_ok = 1'b1; mask_data = 8'h00;

    // Reset state
    tick();
    chk("rst_gnt_lyr",   32'(gnt_lyr),   32'd7);
    chk("rst_tmap_rd",   32'(tmap_rd),   32'd0);
    chk("rst_mask_cs",   32'(mask_cs),   32'd0);
    chk("rst_ld_we",     32'(ld_we),     32'd0);
    chk("rst_stall",     32'(stall),     32'd0);
    chk("rst_overrun",   32'(overrun),   32'd0);
    chk("rst_mask_addr", 32'(mask_addr), 32'd0);
    chk("rst_ld_code",   32'(ld_code),   32'd0);
    rst = 1'b0;
    tick();

    // Single request on layer 2
    mask_data = 8'hA5;
    lyr_req = 6'b000100; push(2, 8'hA5);
    tick(); lyr_req = 6'd0;
    chk("single_stall_n1", 32'(stall),   32'd1);
    chk("single_rd_n1",    32'(tmap_rd), 32'd0);
    tick();
    chk("single_tmap_rd",  32'(tmap_rd), 32'd1);
    chk("single_gnt",      32'(gnt_lyr), 32'd2);
    tick();
    chk("single_rd_pulse", 32'(tmap_rd), 32'd0);
    tick();
    chk("single_cs_entry", 32'(mask_cs),   32'd1);
    chk("single_mask_addr",32'(mask_addr), 32'h091A5);
    tick();
    chk("single_cs_m1",    32'(mask_cs), 32'd1);
    chk("single_no_ld_m1", 32'(ld_we),   32'd0);
    tick();
    chk("single_ld_we",    32'(ld_we),   32'd1);
    chk("single_ld_lyr",   32'(ld_lyr),  32'd2);
    chk("single_ld_code",  32'(ld_code), 32'h1234);
    chk("single_cs_drop",  32'(mask_cs), 32'd0);
    tick();
    chk("single_ld_pulse", 32'(ld_we),   32'd0);
    chk("single_stall_end",32'(stall),   32'd0);
    chk("single_gnt_none", 32'(gnt_lyr), 32'd7);

    // Simultaneous requests, arbiter pointer freshly reset
    hs_edge = 1'b1; tick(); hs_edge = 1'b0; tick();
    mask_data = 8'h3C;
    lyr_req = 6'b110011;
    push(0, 8'h3C); push(1, 8'h3C); push(4, 8'h3C); push(5, 8'h3C);
    tick(); lyr_req = 6'd0;
    run_until_idle(cyc, nld, last_ld);
    chk("burst_loads",     32'(nld),     32'd4);
    chk("burst_last_ld",   32'(last_ld), 32'd23);
    chk("burst_stall_drop",32'(cyc),     32'd24);

    // Slow SDRAM, with a stale ok coincident with MASK entry
    mask_ok = 1'b0; mask_data = 8'h5A;
    lyr_req = 6'b000001; push(0, 8'h5A);
    tick(); lyr_req = 6'd0;
    tick(); tick(); tick();
    chk("slow_cs_entry", 32'(mask_cs), 32'd1);
    mask_ok = 1'b1;
    tick();
    chk("slow_stale_ok_ignored", 32'(ld_we),   32'd0);
    chk("slow_cs_after_stale",   32'(mask_cs), 32'd1);
    mask_ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("slow_cs_held", 32'(mask_cs), 32'd1);
      chk("slow_no_ld",   32'(ld_we),   32'd0);
    end
    mask_ok = 1'b1;
    tick();
    chk("slow_ld_after_ok", 32'(ld_we),   32'd1);
    chk("slow_cs_dropped",  32'(mask_cs), 32'd0);
    tick();
    chk("slow_idle", 32'(stall), 32'd0);

    // Overrun on layer 3
    mask_data = 8'hC3;
    lyr_req = 6'b001000; push(3, 8'hC3);
    tick(); lyr_req = 6'd0;
    tick();
    lyr_req = 6'b001000;
    tick(); lyr_req = 6'd0;
    chk("ovr_set", 32'(overrun), 32'd1);
    run_until_idle(cyc, nld, last_ld);
    chk("ovr_single_load", 32'(nld),     32'd1);
    chk("ovr_sticky",      32'(overrun), 32'd1);
    hs_edge = 1'b1; tick(); hs_edge = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    tick();

    // Flush in MASK with layers 1 and 3 pending; layer 0 requested with the flush
    mask_data = 8'h96;
    lyr_req = 6'b001010;
    tick(); lyr_req = 6'd0;
    tick(); tick(); tick();
    chk("flush_in_mask", 32'(mask_cs), 32'd1);
    chk("flush_gnt",     32'(gnt_lyr), 32'd1);
    hs_edge = 1'b1; lyr_req = 6'b000001; push(0, 8'h96);
    tick(); hs_edge = 1'b0; lyr_req = 6'd0;
    chk("flush_cs",      32'(mask_cs), 32'd0);
    chk("flush_gnt_none",32'(gnt_lyr), 32'd7);
    chk("flush_no_ld",   32'(ld_we),   32'd0);
    chk("flush_stall",   32'(stall),   32'd1);
    run_until_idle(cyc, nld, last_ld);
    chk("flush_one_load", 32'(nld), 32'd1);

    // Disabled layers and inactive window
    lyr_dis = 6'b111111; lyr_req = 6'b111111;
    tick(); lyr_req = 6'd0;
    chk("dis_stall", 32'(stall), 32'd0);
    tick();
    chk("dis_no_rd", 32'(tmap_rd), 32'd0);
    chk("dis_stall2",32'(stall),   32'd0);
    lyr_dis = 6'd0;
    active = 1'b0; lyr_req = 6'b111111;
    tick(); lyr_req = 6'd0; active = 1'b1;
    chk("inact_stall", 32'(stall), 32'd0);
    tick();
    chk("inact_no_rd", 32'(tmap_rd), 32'd0);

    // Asynchronous reset during TMAP
    lyr_req = 6'b100000;
    tick(); lyr_req = 6'd0;
    tick();
    chk("arst_pre_rd",  32'(tmap_rd), 32'd1);
    chk("arst_pre_gnt", 32'(gnt_lyr), 32'd5);
    rst = 1'b1;
    #1;
    chk("arst_rd",      32'(tmap_rd), 32'd0);
    chk("arst_gnt",     32'(gnt_lyr), 32'd7);
    chk("arst_stall",   32'(stall),   32'd0);
    chk("arst_ld_code", 32'(ld_code), 32'd0);
    chk("arst_ld_mask", 32'(ld_mask), 32'd0);
    tick(); rst = 1'b0;
    tick(); tick();
    chk("arst_stays_idle", 32'(tmap_rd), 32'd0);

    chk("sb_all_loads_seen", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
